// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC         = 32'd4;
  localparam logic [XLEN-1:0] HALT_INSTR_DEF = 32'h00000063;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF  = 32'h00000013;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    if (v == {XLEN{1'b1}}) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with redirect / hold / sequential-advance mux.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic            advance_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // Next-PC selection: a redirect overrides the sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (advance_i) begin
      pc_d = pc_q + PC_INC;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, registers {pc, instr, valid} toward decode,
// parks on the halt encoding and latches a sticky error on misaligned redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h00000000,
  parameter logic [XLEN-1:0] HALT_INSTR = HALT_INSTR_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_instr_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic            halted_o,
  output logic            misalign_err_o,
  output logic [XLEN-1:0] fetch_count_o
);

  fetch_state_e    state_d, state_q;
  logic            if_valid_d, if_valid_q;
  logic [XLEN-1:0] if_pc_d, if_pc_q;
  logic [XLEN-1:0] if_instr_d, if_instr_q;
  logic            halted_d, halted_q;
  logic            misalign_d, misalign_q;
  logic [XLEN-1:0] count_d, count_q;
  logic            pc_load_s;
  logic            pc_adv_s;
  logic            redir_bad_s;
  logic [XLEN-1:0] pc_s;

  fetch_unit_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (pc_load_s),
    .load_pc_i (redirect_pc_i),
    .advance_i (pc_adv_s),
    .pc_o      (pc_s)
  );

  assign redir_bad_s = (redirect_pc_i[1:0] != 2'b00);

  // Next-state and next-output decode; redirect > stall > halt detect > fetch.
  always_comb begin
    state_d    = state_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    halted_d   = halted_q;
    misalign_d = misalign_q;
    count_d    = count_q;
    pc_load_s  = 1'b0;
    pc_adv_s   = 1'b0;
    case (state_q)
      ST_RUN, ST_HALT: begin
        if (redirect_valid_i) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          halted_d   = 1'b0;
          if (redir_bad_s) begin
            state_d    = ST_ERR;
            misalign_d = 1'b1;
          end else begin
            state_d   = ST_RUN;
            pc_load_s = 1'b1;
          end
        end else if (stall_i) begin
          if_valid_d = if_valid_q;
        end else if (state_q == ST_HALT) begin
          // Parked: the halt instruction was delivered once, now only bubbles.
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end else if (imem_instr_i == HALT_INSTR) begin
          if_pc_d    = pc_s;
          if_instr_d = HALT_INSTR;
          if_valid_d = 1'b1;
          count_d    = sat_inc(count_q);
          state_d    = ST_HALT;
          halted_d   = 1'b1;
        end else begin
          if_pc_d    = pc_s;
          if_instr_d = imem_instr_i;
          if_valid_d = 1'b1;
          count_d    = sat_inc(count_q);
          pc_adv_s   = 1'b1;
        end
      end
      ST_ERR: begin
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
      end
      default: begin
        state_d    = ST_ERR;
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
        halted_d   = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs toward decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h00000000;
      if_instr_q <= NOP_INSTR;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'h00000000;
    end else begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr_o    = pc_s;
  assign if_valid_o     = if_valid_q;
  assign if_pc_o        = if_pc_q;
  assign if_instr_o     = if_instr_q;
  assign halted_o       = halted_q;
  assign misalign_err_o = misalign_q;
  assign fetch_count_o  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: synthetic memory plus a rule-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'h00000063;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        halted_o;
  logic        misalign_err_o;
  logic [31:0] fetch_count_o;

  int n_checks = 0;
  int n_fails  = 0;

  // memory image controls
  logic        plan_mode = 1'b1;
  logic        halt_en   = 1'b0;
  logic [31:0] halt_addr = 32'h0;
  logic [31:0] seed      = 32'h1234abcd;

  // reference model
  logic [31:0] m_pc, m_ifpc, m_instr, m_count;
  logic        m_valid, m_halted, m_err;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .imem_addr_o(imem_addr_o), .imem_instr_i(imem_instr_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o),
    .halted_o(halted_o), .misalign_err_o(misalign_err_o), .fetch_count_o(fetch_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic plan,
                                           input logic hen, input logic [31:0] hadr,
                                           input logic [31:0] sd);
    logic [31:0] w;
    if (hen && a == hadr) return HALT;
    if (plan && a == 32'h0) return 32'h00500093;
    if (plan && a == 32'h4) return 32'h00600113;
    w = (a * 32'h9E3779B1) ^ sd;
    if (w == HALT) w = w ^ 32'h1;
    return w;
  endfunction

  assign imem_instr_i = mem_word(imem_addr_o, plan_mode, halt_en, halt_addr, seed);

  function automatic logic [130:0] dut_vec();
    return {if_valid_o, if_pc_o, if_instr_o, halted_o, misalign_err_o, fetch_count_o, imem_addr_o};
  endfunction

  function automatic logic [130:0] exp_vec();
    return {m_valid, m_ifpc, m_instr, m_halted, m_err, m_count, m_pc};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_instr = NOP; m_count = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model by the stage's rules, land at posedge+1.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
    logic [31:0] w;
    stall_i = st; redirect_valid_i = rd; redirect_pc_i = tgt;
    w = mem_word(m_pc, plan_mode, halt_en, halt_addr, seed);
    if (m_err) begin
      m_valid = 1'b0; m_instr = NOP;
    end else if (rd) begin
      m_valid = 1'b0; m_instr = NOP; m_halted = 1'b0;
      if (tgt[1:0] != 2'b00) m_err = 1'b1;
      else m_pc = tgt;
    end else if (st) begin
      // everything holds
    end else if (m_halted) begin
      m_valid = 1'b0; m_instr = NOP;
    end else begin
      m_ifpc = m_pc; m_instr = w; m_valid = 1'b1;
      if (m_count != 32'hFFFFFFFF) m_count = m_count + 32'd1;
      if (w == HALT) m_halted = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
    @(posedge clk); #1;
    stall_i = 1'b0; redirect_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fails++; $display("FAIL reset: got %h want %h", dut_vec(), exp_vec());
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_plan_fetch();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL plan_fetch c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({if_pc_o, if_instr_o, fetch_count_o} !== {32'h4, 32'h00600113, 32'd2}) begin
      n_fails++; $display("FAIL plan_fetch_abs: got %h %h %0d want 4 00600113 2", if_pc_o, if_instr_o, fetch_count_o);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      n_checks++;
      if (dut_vec() !== exp_vec() || imem_addr_o !== 32'h8 || if_pc_o !== 32'h4 || if_valid_o !== 1'b1) begin
        n_fails++; $display("FAIL stall c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (dut_vec() !== exp_vec() || if_pc_o !== 32'h8) begin
      n_fails++; $display("FAIL stall_resume: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_redirect_stall();
    cycle(1'b1, 1'b1, 32'h40);
    n_checks++;
    if (dut_vec() !== exp_vec() || if_valid_o !== 1'b0 || if_instr_o !== NOP) begin
      n_fails++; $display("FAIL redirect_bubble: got %h want %h", dut_vec(), exp_vec());
    end
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (dut_vec() !== exp_vec() || if_pc_o !== 32'h40 || if_valid_o !== 1'b1) begin
      n_fails++; $display("FAIL redirect_target: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_halt();
    logic st [0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    halt_en = 1'b1; halt_addr = 32'h10;
    cycle(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 9; i++) begin
      cycle(st[i], 1'b0, 32'h0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL halt c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({halted_o, if_valid_o, imem_addr_o} !== {1'b1, 1'b0, 32'h10}) begin
      n_fails++; $display("FAIL halt_parked: got h=%b v=%b a=%h want 1 0 10", halted_o, if_valid_o, imem_addr_o);
    end
    cycle(1'b0, 1'b1, 32'h0);
    halt_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (dut_vec() !== exp_vec() || halted_o !== 1'b0) begin
        n_fails++; $display("FAIL halt_exit c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b1, 32'hFFFFFFF8);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL wrap c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (if_pc_o !== 32'h0 || imem_addr_o !== 32'h4) begin
      n_fails++; $display("FAIL wrap_abs: got pc=%h addr=%h want 0 4", if_pc_o, imem_addr_o);
    end
  endtask

  task automatic test_random();
    logic        st, rd;
    logic [31:0] tgt;
    plan_mode = 1'b0;
    seed = $urandom;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 8);
      tgt = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      if ($urandom_range(0, 3) == 0) tgt = {28'hFFFFFFF, tgt[3:0]} & 32'hFFFFFFFC;
      if (rd) begin
        halt_en = ($urandom_range(0, 1) == 1);
        halt_addr = tgt + 32'd4 * $urandom_range(0, 6);
      end
      cycle(st, rd, tgt);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL random c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    halt_en = 1'b0;
  endtask

  task automatic test_misalign();
    cycle(1'b0, 1'b1, 32'h42);
    for (int i = 0; i < 6; i++) begin
      cycle(i[0], (i % 3) == 0, 32'h0);
      n_checks++;
      if (dut_vec() !== exp_vec() || misalign_err_o !== 1'b1 || if_valid_o !== 1'b0) begin
        n_fails++; $display("FAIL misalign c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    rst_n = 1'b0; model_reset();
    #2;
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fails++; $display("FAIL misalign_reset: got %h want %h", dut_vec(), exp_vec());
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL misalign_restart c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b1, 32'h18);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (imem_addr_o !== 32'h20 || dut_vec() !== exp_vec()) begin
      n_fails++; $display("FAIL async_pre: got %h want %h", dut_vec(), exp_vec());
    end
    #2; rst_n = 1'b0; model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fails++; $display("FAIL async_reset: got %h want %h", dut_vec(), exp_vec());
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL async_restart c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_plan_fetch();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_wrap();
    test_random();
    test_misalign();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the PC and drives the memory's word address; the memory returns the instruction combinationally in the same cycle.
- Registers {pc, instruction, valid} toward decode and handles stall, redirect (branch/jump) and flush.
- Detects the halt instruction (32'h00000063, beq x0,x0,0) and parks; flags misaligned redirect targets.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- HALT_INSTR, 32'h00000063, encoding that parks the fetch stage.
- NOP_INSTR, 32'h00000013, bubble value driven on if_instr when invalid.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  decode cannot accept; hold PC and outputs.
- redirect_valid_i  input  1  load redirect_pc_i this cycle; flush.
- redirect_pc_i  input  32  redirect target byte address.
- imem_addr_o  output  32  byte address to instruction memory; equals current PC, combinational from the PC register.
- imem_instr_i  input  32  instruction returned for imem_addr_o, same cycle.
- if_valid_o  output  1  if_pc_o and if_instr_o hold a real instruction.
- if_pc_o  output  32  PC of the registered instruction.
- if_instr_o  output  32  registered instruction; NOP_INSTR when invalid.
- halted_o  output  1  fetch parked on a halt instruction.
- misalign_err_o  output  1  sticky: redirect target had pc[1:0] != 0.
- fetch_count_o  output  32  count of instructions delivered valid; saturating.

Behaviour:
- Reset, asynchronous on rst_n low; each value takes effect immediately and holds while low:
  - pc = RESET_PC; state = RUN.
  - if_valid_o = 0; if_pc_o = 0; if_instr_o = NOP_INSTR.
  - halted_o = 0; misalign_err_o = 0; fetch_count_o = 0.
- Deassertion: the first rising edge after rst_n goes high is the first fetch edge.
- States: RUN, HALT, ERR. Latency is 1 cycle from PC to registered output.
- Per-edge priority in RUN is redirect > stall > halt detect > normal fetch:
  - Redirect, aligned: pc <= redirect_pc_i; if_valid_o <= 0; if_instr_o <= NOP_INSTR; if_pc_o unchanged; count unchanged. Stall is ignored on this edge.
  - Redirect, misaligned (redirect_pc_i[1:0] != 0): state <= ERR; misalign_err_o <= 1; if_valid_o <= 0; if_instr_o <= NOP_INSTR; pc unchanged.
  - Stall: pc, if_* and count hold their values; valid is not dropped.
  - Halt (imem_instr_i == HALT_INSTR): the outputs load {pc, HALT_INSTR, valid=1}; count increments; pc is not incremented; state <= HALT; halted_o <= 1.
  - Normal fetch: if_pc_o <= pc; if_instr_o <= imem_instr_i; if_valid_o <= 1; pc <= pc + 4 (mod 2^32, wraps from 32'hFFFFFFFC to 0); count <= count + 1.
- HALT state:
  - imem_addr_o holds the halt PC.
  - If not stalled, if_valid_o <= 0 and if_instr_o <= NOP_INSTR. If stalled, the halt instruction stays valid until accepted.
  - An aligned redirect returns to RUN with halted_o <= 0, with the same semantics as in RUN.
  - A misaligned redirect moves to ERR.
- ERR state:
  - Outputs remain invalid (if_valid_o = 0, if_instr_o = NOP_INSTR); pc and count frozen.
  - Redirects and stalls are ignored. Only reset exits.
- fetch_count_o saturates at 32'hFFFFFFFF and never wraps.
- The block performs no address-range check; out-of-range handling belongs to the memory.
- Reset asserted mid-stall, mid-halt or in ERR: all state is cleared immediately per the reset values.

Decomposition:
- Shared package holds:
  - state enum {RUN, HALT, ERR}.
  - HALT_INSTR and NOP_INSTR constants.
  - XLEN = 32.
  - PC increment constant 4.
- One natural sub-module: pc_reg, holding the PC register plus next-PC mux for redirect, hold and +4.
- Output register, FSM and counter live in fetch_unit.

Test Plan:
- Reset release, memory returns 32'h00500093 at 0x0 and 32'h00600113 at 0x4 -> cycle 1 if_pc=0, instr=00500093, valid=1; cycle 2 if_pc=4, instr=00600113; count=2.
- stall_i held 3 cycles at PC 0x8 -> imem_addr_o stays 0x8; if_pc=4 and valid=1 held; count unchanged; fetch resumes with if_pc=8.
- redirect_valid_i=1 with target 0x40 while stall_i=1 -> next cycle valid=0, instr=00000013; following cycle if_pc=0x40, valid=1.
- Memory returns 00000063 at 0x10 -> if_pc=0x10 valid once, then halted=1, valid=0, imem_addr_o stays 0x10; a redirect to 0x0 clears halted and fetches from 0x0.
- Redirect to 0x42 -> misalign_err=1, valid=0 forever; a later redirect to 0x0 is ignored; rst_n pulse clears the error and restarts from RESET_PC.
- rst_n dropped mid-run at PC 0x20 -> all outputs take reset values asynchronously before the next edge; after release, fetch restarts at 0x0 with count=0.
